gp_fifo: RTL and testbench
==========================

GP_FIFO -- requirements
Module: gp_fifo

Interface
REQ-001 Parameter DATA_W, default 64, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of storage entries; power of two.
REQ-003 Parameter CNT_W, default 5, occupancy width; SHALL equal log2(DEPTH)+1.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  reset, synchronous and active-low.
REQ-006 write_en  input  1  write request; data_in captured at the clk edge while high.
REQ-007 read_en  input  1  read request; pops the head entry at the clk edge while high.
REQ-008 data_in  input  DATA_W  write data.
REQ-009 data_out  output  DATA_W  registered read data.
REQ-010 error  output  1  registered one-cycle flag for an illegal request (overflow or underflow).
REQ-011 full  output  1  high when ocup == DEPTH.
REQ-012 empty  output  1  high when ocup == 0.
REQ-013 ocup  output  CNT_W  current number of stored entries, 0..DEPTH.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH x DATA_W, with a write pointer and a read pointer of log2(DEPTH) bits each; both pointers SHALL wrap from DEPTH-1 to 0.
REQ-015 Accepted write: write_en=1 and (full=0 or read_en=1) -> store data_in at the write pointer, then increment the write pointer.
REQ-016 Accepted read: read_en=1 and empty=0 -> load data_out with the head entry at that edge (1-cycle latency), then increment the read pointer.
REQ-017 data_out SHALL hold its previous value in every cycle with no accepted read.
REQ-018 ocup SHALL be +1 for write only, -1 for read only, and unchanged for both or neither; it SHALL never exceed DEPTH or go below 0.
REQ-019 full and empty SHALL be combinational decodes of the registered ocup; there is no same-cycle bypass.
REQ-020 Simultaneous read and write when full: both are accepted; ocup stays DEPTH; error=0.
REQ-021 Simultaneous read and write when empty: the write is accepted; the read is rejected (data_out unchanged); ocup becomes 1; error=1 for one cycle.
REQ-022 Write with full=1 and read_en=0: data is dropped, pointers and ocup are unchanged, error=1 in the next cycle.
REQ-023 Read with empty=1: data_out, pointers and ocup are unchanged; error=1 in the next cycle.
REQ-024 error SHALL be registered each cycle (overflow OR underflow of the current request) and SHALL be 0 in any cycle that follows a legal or idle cycle; it is not sticky.
REQ-025 Ordering SHALL be strict first-in, first-out across pointer wrap-around.

Reset
REQ-026 When reset=0 at a clk edge: pointers=0, ocup=0, data_out=0, error=0, so empty=1 and full=0; write_en and read_en are ignored in that cycle.
REQ-027 Reset asserted mid-operation SHALL discard all contents at that edge; memory contents need not be cleared.
REQ-028 The first request SHALL be honoured at the first clk edge with reset=1.

Verification
REQ-029 Reset, then write A5A5A5A5A5A5A5A5 for one cycle -> ocup=1, empty=0; the following idle cycles with changing data_in -> ocup stays 1.
REQ-030 Write 35A5A5A5A5A5A5A5, then read twice -> data_out=A5A5A5A5A5A5A5A5, then 35A5A5A5A5A5A5A5; ocup goes 2,1,0; empty=1 at end; error=0 throughout.
REQ-031 Write 16 words 0..15 -> full=1, ocup=16; a 17th write -> error pulses for 1 cycle, ocup=16; reading 16 words returns 0..15 in order.
REQ-032 Read when empty -> error=1 for one cycle, data_out unchanged, ocup=0.
REQ-033 Fill to 16, then do read+write together for 20 cycles (pointer wrap) -> ocup stays 16, full stays 1, output stays in order, error=0.
REQ-034 Assert reset with ocup=5 -> next cycle ocup=0, empty=1, data_out=0, error=0.

Source files
------------

// File: rtl/gp_fifo.sv
`default_nettype none
// ------------------------------------------------------------------------
// gp_fifo : single-clock circular-buffer FIFO with registered read data. Rev 1.0
// ------------------------------------------------------------------------
module gp_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              error,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  ocup
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  C_FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  C_ONE_CNT  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] C_ONE_PTR  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] C_LAST_PTR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  ocup_q, ocup_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              error_q, error_d;

  logic w_full, w_empty, w_wr_acc, w_rd_acc;

  assign w_full  = (ocup_q == C_FULL_CNT);
  assign w_empty = (ocup_q == '0);

  // A write into a full FIFO is legal only when the same-edge read frees a slot.
  assign w_wr_acc = write_en && (!w_full || read_en);
  assign w_rd_acc = read_en && !w_empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ocup_d     = ocup_q;
    data_out_d = data_out_q;
    error_d    = (write_en && !read_en && w_full) || (read_en && w_empty);

    if (w_wr_acc) begin
      wr_ptr_d = (wr_ptr_q == C_LAST_PTR) ? '0 : wr_ptr_q + C_ONE_PTR;
    end
    if (w_rd_acc) begin
      data_out_d = mem_q[rd_ptr_q];
      rd_ptr_d   = (rd_ptr_q == C_LAST_PTR) ? '0 : rd_ptr_q + C_ONE_PTR;
    end

    case ({w_wr_acc, w_rd_acc})
      2'b10:   ocup_d = ocup_q + C_ONE_CNT;
      2'b01:   ocup_d = ocup_q - C_ONE_CNT;
      default: ocup_d = ocup_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ocup_q     <= '0;
      data_out_q <= '0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ocup_q     <= ocup_d;
      data_out_q <= data_out_d;
      error_q    <= error_d;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (reset && w_wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out = data_out_q;
  assign error    = error_q;
  assign full     = w_full;
  assign empty    = w_empty;
  assign ocup     = ocup_q;

endmodule
`default_nettype wire

// File: tb/tb_gp_fifo.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_gp_fifo : queue-model checker and directed stimulus for gp_fifo. Rev 1.0
// ------------------------------------------------------------------------
module tb_gp_fifo;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              write_en = 1'b0;
  logic              read_en = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              error;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  ocup;

  gp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .write_en (write_en),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_out (data_out),
    .error    (error),
    .full     (full),
    .empty    (empty),
    .ocup     (ocup)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain queue plus the last popped word and the error flag.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_dout = '0;
  bit                m_err  = 1'b0;

  always @(posedge clk) begin
    bit m_full, m_empty, do_rd, do_wr;
    if (!reset) begin
      m_q.delete();
      m_dout = '0;
      m_err  = 1'b0;
    end else begin
      m_full  = (m_q.size() == DEPTH);
      m_empty = (m_q.size() == 0);
      do_rd   = read_en && !m_empty;
      do_wr   = write_en && (!m_full || read_en);
      m_err   = (write_en && !read_en && m_full) || (read_en && m_empty);
      if (do_rd) m_dout = m_q.pop_front();
      if (do_wr) m_q.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_data_out", data_out, m_dout);
      chk("cyc_error",    64'(error), 64'(m_err));
      chk("cyc_ocup",     64'(ocup),  64'(m_q.size()));
      chk("cyc_full",     64'(full),  64'(m_q.size() == DEPTH));
      chk("cyc_empty",    64'(empty), 64'(m_q.size() == 0));
    end
  end

  task automatic cyc(input logic we, input logic re, input logic [DATA_W-1:0] d);
    write_en = we;
    read_en  = re;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    cyc(1'b1, 1'b1, 64'hDEAD);
    cyc(1'b0, 1'b0, 64'h0);
    chk_en = 1'b1;
    chk("rst_ocup",  64'(ocup),  64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full",  64'(full),  64'd0);
    chk("rst_dout",  data_out,   64'd0);
    chk("rst_err",   64'(error), 64'd0);
    reset = 1'b1;

    // Single write, then idle with changing data_in
    cyc(1'b1, 1'b0, 64'hA5A5A5A5A5A5A5A5);
    chk("w1_ocup",  64'(ocup),  64'd1);
    chk("w1_empty", 64'(empty), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 64'(i * 7 + 3));
      chk("idle_ocup", 64'(ocup), 64'd1);
    end

    // Second write and two reads
    cyc(1'b1, 1'b0, 64'h35A5A5A5A5A5A5A5);
    chk("w2_ocup", 64'(ocup), 64'd2);
    cyc(1'b0, 1'b1, 64'h0);
    chk("r1_dout", data_out,   64'hA5A5A5A5A5A5A5A5);
    chk("r1_ocup", 64'(ocup),  64'd1);
    cyc(1'b0, 1'b1, 64'h0);
    chk("r2_dout", data_out,   64'h35A5A5A5A5A5A5A5);
    chk("r2_ocup", 64'(ocup),  64'd0);
    chk("r2_empty", 64'(empty), 64'd1);
    chk("r2_err",  64'(error), 64'd0);

    // Underflow
    cyc(1'b0, 1'b1, 64'h0);
    chk("uf_err",  64'(error), 64'd1);
    chk("uf_dout", data_out,   64'h35A5A5A5A5A5A5A5);
    chk("uf_ocup", 64'(ocup),  64'd0);
    cyc(1'b0, 1'b0, 64'h0);
    chk("uf_err_clear", 64'(error), 64'd0);

    // Fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 64'(i));
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ocup", 64'(ocup), 64'd16);
    cyc(1'b1, 1'b0, 64'h99);
    chk("of_err",  64'(error), 64'd1);
    chk("of_ocup", 64'(ocup),  64'd16);
    cyc(1'b0, 1'b0, 64'h0);
    chk("of_err_clear", 64'(error), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, 64'h0);
      chk("drain_order", data_out, 64'(i));
    end
    chk("drain_empty", 64'(empty), 64'd1);

    // Read+write while empty: write taken, read refused
    cyc(1'b1, 1'b1, 64'h77);
    chk("rwe_ocup", 64'(ocup),  64'd1);
    chk("rwe_err",  64'(error), 64'd1);
    chk("rwe_dout", data_out,   64'd15);
    cyc(1'b0, 1'b1, 64'h0);
    chk("rwe_pop", data_out, 64'h77);

    // Full with simultaneous read+write across pointer wrap
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 64'(100 + i));
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 64'(200 + i));
      chk("rwf_dout", data_out, (i < DEPTH) ? 64'(100 + i) : 64'(200 + i - DEPTH));
      chk("rwf_full", 64'(full),  64'd1);
      chk("rwf_err",  64'(error), 64'd0);
    end

    // Mid-operation reset at ocup=5
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, 64'h0);
    chk("pre_rst_ocup", 64'(ocup), 64'd5);
    chk("pre_rst_dout", data_out,  64'd214);
    reset = 1'b0;
    cyc(1'b1, 1'b1, 64'h1234);
    chk("mrst_ocup",  64'(ocup),  64'd0);
    chk("mrst_empty", 64'(empty), 64'd1);
    chk("mrst_dout",  data_out,   64'd0);
    chk("mrst_err",   64'(error), 64'd0);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 64'hABC);
    chk("first_req_ocup", 64'(ocup), 64'd1);
    cyc(1'b0, 1'b1, 64'h0);
    chk("first_req_dout", data_out, 64'hABC);

    // Mixed traffic, checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
          {$urandom(), $urandom()});
    end
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 64'h0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
